// File: rtl/shift_pkg.sv
// Shared types and frame-length helpers for the shift serializer.
// Defining SHIFT_SER_PARITY_EN appends an even-parity bit to every frame.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

`ifdef SHIFT_SER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of serial bits per frame for a given data width.
    function automatic int frame_len(input int w);
        return w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable up-counter with clear, enable and a terminal-count flag.
// The terminal value is a port so one instance can time several phases.
module ser_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count register: clear beats load, load beats increment.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmit stage, LSB first, valid/ready input side.
// Optional even-parity trailer bit when SHIFT_SER_PARITY_EN is defined.
module shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int IDLE_GAP = 0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done
);

    localparam int FRAME    = frame_len(WIDTH);
    localparam int LAST     = FRAME - 1;
    localparam int BW       = $clog2(WIDTH + 1);
    localparam int CW       = (BW > 4) ? BW : 4;
    localparam int GAP_TERM = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

    ser_state_t       r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_frame_done;

    logic [CW-1:0]    w_cnt;
    logic             w_tc;
    logic [CW-1:0]    w_term;
    logic             w_last;
    logic             w_gap_end;
    logic             w_ready;
    logic             w_accept;
    logic [CW-1:0]    w_nxt_idx;
    logic [WIDTH-1:0] w_shifted;
    logic             w_nxt_bit;

    assign w_term    = (r_state == GAP) ? CW'(GAP_TERM) : CW'(LAST);
    assign w_last    = (r_state == SHIFT) && w_tc;
    assign w_gap_end = (r_state == GAP) && w_tc;
    assign w_ready   = (r_state == IDLE) || (w_last && (IDLE_GAP == 0));
    assign w_accept  = din_valid && w_ready;
    assign w_nxt_idx = w_cnt + 1'b1;
    assign w_shifted = r_hold >> w_nxt_idx;

`ifdef SHIFT_SER_PARITY_EN
    assign w_nxt_bit = (w_nxt_idx == CW'(WIDTH)) ? ^r_hold : w_shifted[0];
`else
    assign w_nxt_bit = w_shifted[0];
`endif

    // One counter times both the bit position and the idle gap.
    ser_bit_counter #(
        .W (CW)
    ) u_cnt (
        .clk        (clk),
        .rstb       (rstb),
        .i_clr      (w_accept || w_last || w_gap_end),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       ((r_state != IDLE) && !w_tc),
        .i_term     (w_term),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    // Frame FSM with registered serial outputs; bit 0 leaves on the accept edge.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_ser_out    <= 1'b0;
            r_ser_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_hold       <= din;
                        r_ser_out    <= din[0];
                        r_ser_valid  <= 1'b1;
                        r_frame_done <= 1'b0;
                        r_state      <= SHIFT;
                    end else begin
                        r_ser_out    <= 1'b0;
                        r_ser_valid  <= 1'b0;
                        r_frame_done <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!w_tc) begin
                        r_ser_out    <= w_nxt_bit;
                        r_ser_valid  <= 1'b1;
                        r_frame_done <= (w_nxt_idx == CW'(LAST));
                    end else if (IDLE_GAP > 0) begin
                        r_ser_out    <= 1'b0;
                        r_ser_valid  <= 1'b0;
                        r_frame_done <= 1'b0;
                        r_state      <= GAP;
                    end else if (w_accept) begin
                        r_hold       <= din;
                        r_ser_out    <= din[0];
                        r_ser_valid  <= 1'b1;
                        r_frame_done <= 1'b0;
                    end else begin
                        r_ser_out    <= 1'b0;
                        r_ser_valid  <= 1'b0;
                        r_frame_done <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                GAP: begin
                    r_ser_out    <= 1'b0;
                    r_ser_valid  <= 1'b0;
                    r_frame_done <= 1'b0;
                    if (w_tc) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ser_out    <= 1'b0;
                    r_ser_valid  <= 1'b0;
                    r_frame_done <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign din_ready  = w_ready;
    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer: one gapless and one IDLE_GAP=3 instance.
// Parity expectations follow SHIFT_SER_PARITY_EN.
module tb_shift_serializer;

`ifdef SHIFT_SER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rstb;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       frame_done;

    logic [7:0] g_din;
    logic       g_din_valid;
    logic       g_din_ready;
    logic       g_ser_out;
    logic       g_ser_valid;
    logic       g_frame_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_serializer #(.WIDTH(8), .IDLE_GAP(0)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .frame_done (frame_done)
    );

    shift_serializer #(.WIDTH(8), .IDLE_GAP(3)) dut_g (
        .clk        (clk),
        .rstb       (rstb),
        .din        (g_din),
        .din_valid  (g_din_valid),
        .din_ready  (g_din_ready),
        .ser_out    (g_ser_out),
        .ser_valid  (g_ser_valid),
        .frame_done (g_frame_done)
    );

    // Expected serial bit i of a frame carrying word w.
    function automatic logic exp_bit(input logic [7:0] w, input int i);
        logic [7:0] t;
        if (i >= 8) return ^w;
        t = w >> i;
        return t[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        din = 8'h00; din_valid = 1'b0;
        g_din = 8'h00; g_din_valid = 1'b0;
        tick(); tick();
        n_vec++;
        if ({ser_valid, ser_out, frame_done, din_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_main: got %b need 0001",
                     {ser_valid, ser_out, frame_done, din_ready});
        end
        n_vec++;
        if ({g_ser_valid, g_ser_out, g_frame_done, g_din_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_gap: got %b need 0001",
                     {g_ser_valid, g_ser_out, g_frame_done, g_din_ready});
        end
        rstb = 1'b1;
        tick();
        n_vec++;
        if ({ser_valid, din_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_release: got %b need 01", {ser_valid, din_ready});
        end
    endtask

    task automatic test_single();
        logic [7:0] sr;
        logic [3:0] exp;
        sr = 8'h00;
        din = 8'hA5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0; din = 8'h00;
        for (int i = 0; i < FL; i++) begin
            exp = {1'b1, exp_bit(8'hA5, i), (i == FL - 1), (i == FL - 1)};
            n_vec++;
            if ({ser_valid, ser_out, frame_done, din_ready} !== exp) begin
                n_err++;
                $display("FAIL single_bit%0d: got %b need %b", i,
                         {ser_valid, ser_out, frame_done, din_ready}, exp);
            end
            if (ser_valid) sr = {ser_out, sr[7:1]};
            tick();
        end
`ifndef SHIFT_SER_PARITY_EN
        n_vec++;
        if (sr !== 8'hA5) begin
            n_err++;
            $display("FAIL single_reassembled: got %h need a5", sr);
        end
`endif
        n_vec++;
        if ({ser_valid, ser_out, frame_done, din_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL single_after: got %b need 0001",
                     {ser_valid, ser_out, frame_done, din_ready});
        end
    endtask

    // Two words with din_valid held; w1 is presented while w0 is busy.
    task automatic run_pair(input logic [7:0] w0, input logic [7:0] w1,
                            input string tag);
        logic [7:0] w;
        logic [3:0] exp;
        int k;
        din = w0; din_valid = 1'b1;
        tick();
        din = w1;
        for (int i = 0; i < 2 * FL; i++) begin
            w = (i < FL) ? w0 : w1;
            k = i % FL;
            exp = {1'b1, exp_bit(w, k), (k == FL - 1), (k == FL - 1)};
            n_vec++;
            if ({ser_valid, ser_out, frame_done, din_ready} !== exp) begin
                n_err++;
                $display("FAIL %s_bit%0d: got %b need %b", tag, i,
                         {ser_valid, ser_out, frame_done, din_ready}, exp);
            end
            tick();
            if (i == FL - 1) din_valid = 1'b0;
        end
        n_vec++;
        if ({ser_valid, ser_out, frame_done, din_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL %s_after: got %b need 0001", tag,
                     {ser_valid, ser_out, frame_done, din_ready});
        end
    endtask

    task automatic test_back_to_back();
        run_pair(8'h01, 8'h80, "b2b");
    endtask

    task automatic test_backpressure();
        run_pair(8'h5A, 8'hFF, "bp");
    endtask

    task automatic test_gap();
        logic [3:0] exp;
        g_din = 8'h01; g_din_valid = 1'b1;
        tick();
        g_din = 8'h80;
        for (int i = 0; i < FL; i++) begin
            exp = {1'b1, exp_bit(8'h01, i), (i == FL - 1), 1'b0};
            n_vec++;
            if ({g_ser_valid, g_ser_out, g_frame_done, g_din_ready} !== exp) begin
                n_err++;
                $display("FAIL gap_f0_bit%0d: got %b need %b", i,
                         {g_ser_valid, g_ser_out, g_frame_done, g_din_ready}, exp);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({g_ser_valid, g_ser_out, g_frame_done, g_din_ready} !== 4'b0000) begin
                n_err++;
                $display("FAIL gap_idle%0d: got %b need 0000", i,
                         {g_ser_valid, g_ser_out, g_frame_done, g_din_ready});
            end
            tick();
        end
        n_vec++;
        if ({g_ser_valid, g_ser_out, g_frame_done, g_din_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL gap_accept_cycle: got %b need 0001",
                     {g_ser_valid, g_ser_out, g_frame_done, g_din_ready});
        end
        tick();
        g_din_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            exp = {1'b1, exp_bit(8'h80, i), (i == FL - 1), 1'b0};
            n_vec++;
            if ({g_ser_valid, g_ser_out, g_frame_done, g_din_ready} !== exp) begin
                n_err++;
                $display("FAIL gap_f1_bit%0d: got %b need %b", i,
                         {g_ser_valid, g_ser_out, g_frame_done, g_din_ready}, exp);
            end
            tick();
        end
        n_vec++;
        if ({g_ser_valid, g_din_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL gap_tail: got %b need 00", {g_ser_valid, g_din_ready});
        end
        repeat (4) tick();
        n_vec++;
        if ({g_ser_valid, g_din_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL gap_back_idle: got %b need 01", {g_ser_valid, g_din_ready});
        end
    endtask

    task automatic test_mid_reset();
        din = 8'h3C; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({ser_valid, ser_out} !== {1'b1, exp_bit(8'h3C, i)}) begin
                n_err++;
                $display("FAIL midrst_bit%0d: got %b need %b", i,
                         {ser_valid, ser_out}, {1'b1, exp_bit(8'h3C, i)});
            end
            if (i < 4) tick();
        end
        rstb = 1'b0;
        tick();
        n_vec++;
        if ({ser_valid, ser_out, frame_done, din_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL midrst_abort: got %b need 0001",
                     {ser_valid, ser_out, frame_done, din_ready});
        end
        rstb = 1'b1;
        for (int i = 0; i < FL; i++) begin
            tick();
            n_vec++;
            if ({ser_valid, ser_out, frame_done, din_ready} !== 4'b0001) begin
                n_err++;
                $display("FAIL midrst_residue%0d: got %b need 0001", i,
                         {ser_valid, ser_out, frame_done, din_ready});
            end
        end
        rstb = 1'b0; din = 8'hFF; din_valid = 1'b1;
        tick();
        rstb = 1'b1; din_valid = 1'b0;
        n_vec++;
        if ({ser_valid, ser_out, frame_done, din_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_accept_edge: got %b need 0001",
                     {ser_valid, ser_out, frame_done, din_ready});
        end
        tick();
        n_vec++;
        if ({ser_valid, ser_out, frame_done, din_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_accept_dropped: got %b need 0001",
                     {ser_valid, ser_out, frame_done, din_ready});
        end
    endtask

`ifdef SHIFT_SER_PARITY_EN
    task automatic test_parity();
        logic [8:0] bits;
        logic [8:0] t;
        logic [3:0] exp;
        bits = 9'b1_0000_0111;
        din = 8'h07; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            t = bits >> i;
            exp = {1'b1, t[0], (i == 8), (i == 8)};
            n_vec++;
            if ({ser_valid, ser_out, frame_done, din_ready} !== exp) begin
                n_err++;
                $display("FAIL parity_bit%0d: got %b need %b", i,
                         {ser_valid, ser_out, frame_done, din_ready}, exp);
            end
            tick();
        end
        n_vec++;
        if ({ser_valid, din_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL parity_after: got %b need 01", {ser_valid, din_ready});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_gap();
        test_mid_reset();
`ifdef SHIFT_SER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
